// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline register with valid/ready handshake, a one-word skid entry and flush bubbles.
// Optional stall counter output enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_pipe_stage #(
  parameter int CTRL_W   = 15,
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 4,
  parameter int RD_W     = 5
`ifdef ID_EX_STALL_CNT_EN
  ,
  parameter int CNT_W    = 32
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]            in_rd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [RD_W-1:0]            out_rd,
  output logic [1:0]                 occupancy
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]           stall_cycles
`endif
);

  logic                       r_main_valid;
  logic [CTRL_W-1:0]          r_main_ctrl;
  logic [NUM_DATA*DATA_W-1:0] r_main_data;
  logic [RD_W-1:0]            r_main_rd;
  logic                       r_skid_valid;
  logic [CTRL_W-1:0]          r_skid_ctrl;
  logic [NUM_DATA*DATA_W-1:0] r_skid_data;
  logic [RD_W-1:0]            r_skid_rd;

  logic w_main_adv;
  logic w_accept;

  // Handshake: a word moves across a port in any cycle where that port's valid and ready are
  // both high at the rising edge. in_ready depends only on registered state, never on out_ready.
  assign in_ready   = reset | ~r_skid_valid;
  assign w_accept   = in_valid & ~r_skid_valid;
  assign w_main_adv = ~r_main_valid | out_ready;

  assign out_valid = r_main_valid;
  assign out_ctrl  = r_main_valid ? r_main_ctrl : '0;
  assign out_data  = r_main_data;
  assign out_rd    = r_main_rd;
  assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_main_data  <= '0;
      r_main_rd    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
      r_skid_data  <= '0;
      r_skid_rd    <= '0;
    end else if (flush) begin
      // Data and rd are left alone; only the control words are zeroed.
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
    end else if (w_main_adv) begin
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_ctrl  <= r_skid_ctrl;
        r_main_data  <= r_skid_data;
        r_main_rd    <= r_skid_rd;
        r_skid_valid <= w_accept;
        if (w_accept) begin
          r_skid_ctrl <= in_ctrl;
          r_skid_data <= in_data;
          r_skid_rd   <= in_rd;
        end
      end else begin
        r_main_valid <= w_accept;
        if (w_accept) begin
          r_main_ctrl <= in_ctrl;
          r_main_data <= in_data;
          r_main_rd   <= in_rd;
        end
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_ctrl  <= in_ctrl;
      r_skid_data  <= in_data;
      r_skid_rd    <= in_rd;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating; flush deliberately does not clear it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (r_main_valid & ~out_ready & ~(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage: queue-based reference model checked every cycle plus directed literal checks.
module tb_id_ex_pipe_stage;

  localparam int CTRL_W = 15;
  localparam int DATA_W = 32;
  localparam int NUM_D  = 4;
  localparam int RD_W   = 5;
  localparam int DW     = NUM_D * DATA_W;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DW-1:0]     in_data;
  logic [RD_W-1:0]   in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DW-1:0]     out_data;
  logic [RD_W-1:0]   out_rd;
  logic [1:0]        occupancy;

  int n_cmp;
  int n_err;
  bit chk_en;

  // clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0]       stall_cycles;
  logic              in_ready3;
  logic              out_valid3;
  logic [CTRL_W-1:0] out_ctrl3;
  logic [DW-1:0]     out_data3;
  logic [RD_W-1:0]   out_rd3;
  logic [1:0]        occupancy3;
  logic [2:0]        stall_cycles3;
`endif

  id_ex_pipe_stage #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_DATA(NUM_D), .RD_W(RD_W)
`ifdef ID_EX_STALL_CNT_EN
    , .CNT_W(32)
`endif
  ) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .out_rd(out_rd), .occupancy(occupancy)
`ifdef ID_EX_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

`ifdef ID_EX_STALL_CNT_EN
  id_ex_pipe_stage #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_DATA(NUM_D), .RD_W(RD_W), .CNT_W(3)
  ) u_dut3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3), .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd),
    .out_valid(out_valid3), .out_ready(out_ready), .out_ctrl(out_ctrl3), .out_data(out_data3),
    .out_rd(out_rd3), .occupancy(occupancy3), .stall_cycles(stall_cycles3)
  );
`endif

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two words; the head is what execute sees.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DW-1:0]     data;
    logic [RD_W-1:0]   rd;
  } ent_t;

  ent_t    mq[$];
  longint  m_cnt;
  int      m_cnt3;
  bit      m_ov;
  bit      m_ir;
  ent_t    m_new;

  always @(posedge clk) begin
    m_ov = (mq.size() > 0);
    m_ir = (mq.size() < 2);
    if (reset) begin
      mq.delete();
      m_cnt  = 0;
      m_cnt3 = 0;
    end else begin
      if (m_ov && !out_ready) begin
        if (m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_cnt3 < 7) m_cnt3 = m_cnt3 + 1;
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (m_ov && out_ready) void'(mq.pop_front());
        if (in_valid && m_ir) begin
          m_new.ctrl = in_ctrl;
          m_new.data = in_data;
          m_new.rd   = in_rd;
          mq.push_back(m_new);
        end
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("occupancy", occupancy, mq.size());
      chk("out_valid", out_valid, mq.size() != 0);
      chk("in_ready", in_ready, reset || mq.size() < 2);
      if (mq.size() != 0) begin
        chk("out_ctrl", out_ctrl, mq[0].ctrl);
        chk("out_data", out_data, mq[0].data);
        chk("out_rd", out_rd, mq[0].rd);
      end else begin
        chk("out_ctrl_bubble", out_ctrl, '0);
      end
`ifdef ID_EX_STALL_CNT_EN
      chk("stall_cycles", stall_cycles, m_cnt);
      chk("stall_cycles3", stall_cycles3, m_cnt3);
      chk("out_valid3", out_valid3, mq.size() != 0);
`endif
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [CTRL_W-1:0] c,
                       input logic [RD_W-1:0] rd);
    in_valid = v;
    in_ctrl  = c;
    in_rd    = rd;
    in_data  = {pc ^ 32'hAAAA_0000, pc + 32'h2222_0000, pc + 32'h1111_0000, pc};
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    chk_en    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'h40, '1, 5'd31);

    // reset with in_valid held high
    tick();
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_ctrl", out_ctrl, '0);
    chk("rst_occ", occupancy, 2'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_rd", out_rd, '0);
    chk_en = 1;
    reset  = 1'b0;
    drive(1'b0, 32'h0, '0, '0);
    tick();

    // streaming
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(4 * i), 15'(i + 1), 5'(i + 1));
      tick();
      chk("stream_pc", out_data[31:0], 128'(4 * i));
      chk("stream_occ", occupancy, 2'd1);
      chk("stream_in_ready", in_ready, 1'b1);
    end
    drive(1'b0, 32'h0, '0, '0);
    tick();
    chk("stream_drained", out_valid, 1'b0);

    // back-pressure
    out_ready = 1'b0;
    drive(1'b1, 32'hA00, 15'h0A, 5'd10);
    tick();
    drive(1'b1, 32'hB00, 15'h0B, 5'd11);
    tick();
    chk("bp_occ2", occupancy, 2'd2);
    chk("bp_in_ready0", in_ready, 1'b0);
    drive(1'b1, 32'hC00, 15'h0C, 5'd12);
    tick();
    chk("bp_hold_A", out_data[31:0], 128'h0A00);
    chk("bp_hold_occ", occupancy, 2'd2);
    out_ready = 1'b1;
    tick();
    chk("bp_B", out_data[31:0], 128'h0B00);
    chk("bp_occ1", occupancy, 2'd1);
    tick();
    chk("bp_C", out_data[31:0], 128'h0C00);
    chk("bp_C_rd", out_rd, 128'd12);
    drive(1'b0, 32'h0, '0, '0);
    tick();
    chk("bp_empty", occupancy, 2'd0);

    // flush with two held words and one offered
    out_ready = 1'b0;
    drive(1'b1, 32'hD00, 15'h7FF0, 5'd1);
    tick();
    drive(1'b1, 32'hE00, 15'h7FF1, 5'd2);
    tick();
    drive(1'b1, 32'hF00, 15'h7FF2, 5'd3);
    flush = 1'b1;
    tick();
    chk("fl_out_valid", out_valid, 1'b0);
    chk("fl_out_ctrl", out_ctrl, '0);
    chk("fl_occ", occupancy, 2'd0);
    chk("fl_in_ready", in_ready, 1'b1);
    flush = 1'b0;
    drive(1'b0, 32'h0, '0, '0);
    tick();
    chk("fl_dropped", out_valid, 1'b0);

    // bubbles with all-ones control on the input
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h123, '1, 5'd31);
      tick();
      chk("bubble_ctrl", out_ctrl, '0);
      chk("bubble_valid", out_valid, 1'b0);
    end

    // mixed traffic checked by the model
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 15'($urandom), 5'($urandom));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 11) == 0);
      tick();
    end
    flush = 1'b0;

`ifdef ID_EX_STALL_CNT_EN
    reset = 1'b1;
    drive(1'b0, 32'h0, '0, '0);
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    drive(1'b1, 32'h500, 15'h1, 5'd1);
    tick();
    drive(1'b0, 32'h0, '0, '0);
    for (int i = 0; i < 5; i++) tick();
    chk("stall_5", stall_cycles, 128'd5);
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("stall_kept_after_flush", stall_cycles, 128'd5);
    out_ready = 1'b0;
    drive(1'b1, 32'h600, 15'h2, 5'd2);
    tick();
    drive(1'b0, 32'h0, '0, '0);
    for (int i = 0; i < 10; i++) tick();
    chk("stall_15", stall_cycles, 128'd15);
    chk("stall3_sat", stall_cycles3, 128'd7);
`endif

    out_ready = 1'b1;
    drive(1'b0, 32'h0, '0, '0);
    tick();
    tick();
    chk("final_empty", occupancy, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
